// File: rtl/pwm_dt_multich.sv
// Multichannel complementary PWM with dead-time insertion. One free-running period
// counter feeds every channel. Duty/dead-time updates are shadowed until the period boundary.

module pwm_dt_multich_chk #(
  parameter int NCH = 2
) (
  input logic           clk,
  input logic           rst_n,
  input logic [NCH-1:0] pwm_hi,
  input logic [NCH-1:0] pwm_lo
);
  // The high-side and low-side switches of one pair must never both be on.
  a_no_shoot_through: assert property (@(posedge clk) disable iff (!rst_n)
    ((pwm_hi & pwm_lo) == {NCH{1'b0}}));
endmodule

module pwm_dt_multich #(
  parameter int WIDTH = 12,
  parameter int NCH   = 2,
  parameter int DT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 duty_wr,
  input  logic [NCH*WIDTH-1:0] duty,
  input  logic [DT_W-1:0]      deadtime,
  output logic [NCH-1:0]       pwm_hi,
  output logic [NCH-1:0]       pwm_lo,
  output logic                 period_start
);

  // Compare width wide enough that duty + dead time never wraps.
  localparam int CW = ((DT_W > WIDTH) ? DT_W : WIDTH) + 1;
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [CW-1:0]    LO_LIM  = CW'(CNT_MAX) - CW'(1'b1);

  logic [WIDTH-1:0]     r_cnt;
  logic                 r_run;
  logic [NCH*WIDTH-1:0] r_pend_duty;
  logic [DT_W-1:0]      r_pend_dt;
  logic [NCH*WIDTH-1:0] r_act_duty;
  logic [DT_W-1:0]      r_act_dt;
  logic [NCH-1:0]       r_pwm_hi;
  logic [NCH-1:0]       r_pwm_lo;
  logic                 r_period_start;

  logic                 w_at_max;
  logic                 w_load;
  logic [CW-1:0]        w_cnt_ext;
  logic [CW-1:0]        w_dt_ext;
  logic [NCH-1:0]       w_hi_nxt;
  logic [NCH-1:0]       w_lo_nxt;

  // Load decision and per-channel next-state drive.
  always_comb begin
    w_at_max  = (r_cnt == CNT_MAX);
    w_load    = en & (~r_run | w_at_max);
    w_cnt_ext = CW'(r_cnt);
    w_dt_ext  = CW'(r_act_dt);
    w_hi_nxt  = {NCH{1'b0}};
    w_lo_nxt  = {NCH{1'b0}};
    for (int k = 0; k < NCH; k++) begin
      logic [WIDTH-1:0] v_duty;
      logic [CW-1:0]    v_sum;
      v_duty = r_act_duty[k*WIDTH +: WIDTH];
      v_sum  = CW'(v_duty) + w_dt_ext;
      // Outputs stay low while the counter is parked waiting for its first load.
      if (r_run) begin
        w_hi_nxt[k] = (w_cnt_ext >= w_dt_ext) & (r_cnt < v_duty);
        w_lo_nxt[k] = (v_sum <= LO_LIM) & (w_cnt_ext >= v_sum) & ~w_at_max;
      end else begin
        w_hi_nxt[k] = 1'b0;
        w_lo_nxt[k] = 1'b0;
      end
    end
  end

  // Pending (shadow) registers, written whenever the host strobes duty_wr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_duty <= {(NCH*WIDTH){1'b0}};
      r_pend_dt   <= {DT_W{1'b0}};
    end else if (duty_wr) begin
      r_pend_duty <= duty;
      r_pend_dt   <= deadtime;
    end
  end

  // Period counter, active-register load and registered gate drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt          <= {WIDTH{1'b0}};
      r_run          <= 1'b0;
      r_act_duty     <= {(NCH*WIDTH){1'b0}};
      r_act_dt       <= {DT_W{1'b0}};
      r_pwm_hi       <= {NCH{1'b0}};
      r_pwm_lo       <= {NCH{1'b0}};
      r_period_start <= 1'b0;
    end else if (!en) begin
      r_cnt          <= {WIDTH{1'b0}};
      r_run          <= 1'b0;
      r_pwm_hi       <= {NCH{1'b0}};
      r_pwm_lo       <= {NCH{1'b0}};
      r_period_start <= 1'b0;
    end else begin
      r_pwm_hi       <= w_hi_nxt;
      r_pwm_lo       <= w_lo_nxt;
      r_period_start <= w_load;
      if (w_load) begin
        r_act_duty <= r_pend_duty;
        r_act_dt   <= r_pend_dt;
        r_cnt      <= {WIDTH{1'b0}};
        r_run      <= 1'b1;
      end else begin
        r_cnt <= r_cnt + {{(WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  assign pwm_hi       = r_pwm_hi;
  assign pwm_lo       = r_pwm_lo;
  assign period_start = r_period_start;

  pwm_dt_multich_chk #(.NCH(NCH)) u_chk (
    .clk    (clk),
    .rst_n  (rst_n),
    .pwm_hi (r_pwm_hi),
    .pwm_lo (r_pwm_lo)
  );

endmodule
